// File: rtl/sme_pkg.sv
// Shared types and limits for the string-match-engine scheduler.
package sme_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STR,
        PAT,
        HOLD,
        WAIT,
        RESP
    } sme_state_e;

    localparam logic TYPE_STR = 1'b0;
    localparam logic TYPE_PAT = 1'b1;

    localparam int MAX_STR_LEN = 32;
    localparam int MAX_PAT_LEN = 8;

    // True when a beat arriving with cnt beats already taken exceeds the packet limit
    function automatic logic over_len(input logic ptype, input logic [5:0] cnt);
        return ptype ? (cnt >= 6'(MAX_PAT_LEN)) : (cnt >= 6'(MAX_STR_LEN));
    endfunction

endpackage

// File: rtl/sme_rr_arb.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module sme_rr_arb (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_any,
    output logic       gnt_id
);

    // Single requester wins outright; both requesting alternates against last_grant
    always_comb begin
        gnt_any = |req;
        gnt_id  = 1'b0;
        if (&req) gnt_id = ~last_grant;
        else      gnt_id = req[1];
    end

endmodule

// File: rtl/sme_sched.sv
// Schedules string/pattern packets from two requesters onto one match engine and
// returns the engine result (or a watchdog timeout) to the owning requester.
module sme_sched
    import sme_pkg::*;
#(
    parameter int WDOG_CYC = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_type,
    input  logic [15:0] req_char,
    input  logic [1:0]  req_last,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_id,
    output logic        res_match,
    output logic [4:0]  res_index,
    output logic        res_timeout,
    output logic        len_err,
    output logic [7:0]  sme_chardata,
    output logic        sme_isstring,
    output logic        sme_ispattern,
    input  logic        sme_valid,
    input  logic        sme_match,
    input  logic [4:0]  sme_match_index
);

    localparam int WD_W = $clog2(WDOG_CYC) + 1;

    sme_state_e      state, nxt_state;
    logic            owner, ptype, last_grant;
    logic [5:0]      beat_cnt, cur_cnt;
    logic [WD_W-1:0] wdog;
    logic            gnt_any, gnt_id, gnt_type;
    logic            acc, beat_type, beat_last, drop, fwd, wdog_done;
    logic [7:0]      beat_char;

    sme_rr_arb u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .gnt_any    (gnt_any),
        .gnt_id     (gnt_id)
    );

    assign gnt_type  = req_type[gnt_id];
    assign beat_char = owner ? req_char[15:8] : req_char[7:0];
    assign beat_last = req_last[owner];
    assign wdog_done = (wdog == WD_W'(WDOG_CYC - 1));
    assign drop      = acc && over_len(beat_type, cur_cnt);
    assign fwd       = acc && !drop;
    assign res_valid = (state == RESP);
    assign res_id    = owner;

    // Next state, owner handshake and beat classification
    always_comb begin
        nxt_state = state;
        req_ready = '0;
        acc       = 1'b0;
        beat_type = ptype;
        cur_cnt   = beat_cnt;
        case (state)
            IDLE: if (gnt_any) nxt_state = (gnt_type == TYPE_PAT) ? PAT : STR;
            STR, PAT, HOLD: begin
                req_ready[owner] = 1'b1;
                acc = req_valid[owner];
                // A beat in HOLD opens a new packet whose type comes from the beat itself
                if (state == HOLD) begin
                    beat_type = req_type[owner];
                    cur_cnt   = '0;
                end
                if (acc) begin
                    if (beat_last) nxt_state = (beat_type == TYPE_PAT) ? WAIT : HOLD;
                    else           nxt_state = (beat_type == TYPE_PAT) ? PAT  : STR;
                end
            end
            WAIT: if (sme_valid || wdog_done) nxt_state = RESP;
            RESP: if (res_ready) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt_state;
    end

    // Grant latch, beat counting, engine drive, watchdog and result capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner         <= 1'b0;
            ptype         <= TYPE_STR;
            last_grant    <= 1'b1;
            beat_cnt      <= '0;
            wdog          <= '0;
            sme_chardata  <= '0;
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b0;
            len_err       <= 1'b0;
            res_match     <= 1'b0;
            res_index     <= '0;
            res_timeout   <= 1'b0;
        end else begin
            sme_isstring  <= fwd && (beat_type == TYPE_STR);
            sme_ispattern <= fwd && (beat_type == TYPE_PAT);
            len_err       <= drop;
            if (fwd) sme_chardata <= beat_char;
            case (state)
                IDLE: if (gnt_any) begin
                    owner    <= gnt_id;
                    ptype    <= gnt_type;
                    beat_cnt <= '0;
                end
                STR, PAT, HOLD: if (acc) begin
                    ptype <= beat_type;
                    wdog  <= '0;
                    // Saturate so long over-length packets never wrap back under the limit
                    if (beat_last)             beat_cnt <= '0;
                    else if (cur_cnt != 6'h3f) beat_cnt <= cur_cnt + 6'd1;
                    else                       beat_cnt <= cur_cnt;
                end
                WAIT: begin
                    if (sme_valid) begin
                        res_match   <= sme_match;
                        res_index   <= sme_match_index;
                        res_timeout <= 1'b0;
                    end else if (wdog_done) begin
                        res_match   <= 1'b0;
                        res_index   <= '0;
                        res_timeout <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: if (res_ready) last_grant <= owner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sme_sched.sv
// Randomized bench for sme_sched: requester drivers, engine responder and a
// job-level model predicting forwarded characters, overflow pulses and results.
module tb_sme_sched;

    localparam int WDOG    = 1024;
    localparam int STR_CAP = 32;
    localparam int PAT_CAP = 8;
    localparam int DEPTH   = 4096;

    typedef struct packed { logic typ; logic first; logic last; logic [7:0] ch; } beat_t;
    typedef struct packed { logic typ; logic [7:0] ch; } fwd_t;
    typedef struct { logic id; logic match; logic [4:0] idx; logic tmo; int lenerr; } res_t;
    typedef struct { int delay; bit never; logic match; logic [4:0] idx; } eng_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, req_type, req_last;
    logic [15:0] req_char;
    logic        res_valid, res_ready, res_id, res_match, res_timeout, len_err;
    logic [4:0]  res_index;
    logic [7:0]  sme_chardata;
    logic        sme_isstring, sme_ispattern, sme_valid, sme_match;
    logic [4:0]  sme_match_index;
    logic [21:0] outs;

    sme_sched #(.WDOG_CYC(WDOG)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_type        (req_type),
        .req_char        (req_char),
        .req_last        (req_last),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_id          (res_id),
        .res_match       (res_match),
        .res_index       (res_index),
        .res_timeout     (res_timeout),
        .len_err         (len_err),
        .sme_chardata    (sme_chardata),
        .sme_isstring    (sme_isstring),
        .sme_ispattern   (sme_ispattern),
        .sme_valid       (sme_valid),
        .sme_match       (sme_match),
        .sme_match_index (sme_match_index)
    );

    assign outs = {req_ready, res_valid, res_id, res_match, res_index, res_timeout,
                   len_err, sme_chardata, sme_isstring, sme_ispattern};

    always #5 clk = ~clk;

    int    checks = 0, errors = 0;
    beat_t mem [2][DEPTH];
    int    hd [2] = '{0, 0};
    int    tl [2] = '{0, 0};
    fwd_t  exp_fwd [$];
    res_t  exp_res [$];
    eng_t  eng_q [$];
    int    job_lenerr = 0, lenerr_cnt = 0;
    bit    waiting = 0, e_never = 0, lat_on = 0, bad_ready = 0;
    int    timer = 0, lat_cnt = 0, lat_exp = 0;
    logic  e_match = 1'b0;
    logic [4:0] e_idx = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Queue one packet's beats and the characters the engine should see from it
    task automatic add_pkt(input int id, input logic typ, input byte q[$], input bit first);
        int    cap;
        beat_t b;
        fwd_t  f;
        cap = typ ? PAT_CAP : STR_CAP;
        for (int k = 0; k < q.size(); k++) begin
            b.typ   = typ;
            b.first = first && (k == 0);
            b.last  = (k == q.size() - 1);
            b.ch    = q[k];
            mem[id][tl[id]] = b;
            tl[id]++;
            if (k < cap) begin
                f.typ = typ;
                f.ch  = q[k];
                exp_fwd.push_back(f);
            end else begin
                job_lenerr++;
            end
        end
    endtask

    task automatic add_str(input int id, input logic typ, input string s, input bit first);
        byte q[$];
        for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
        add_pkt(id, typ, q, first);
    endtask

    task automatic add_rnd(input int id, input logic typ, input int len, input bit first);
        byte q[$];
        for (int k = 0; k < len; k++) q.push_back(byte'($urandom_range(97, 122)));
        add_pkt(id, typ, q, first);
    endtask

    // Close a job: engine behaviour and the result the requester should receive
    task automatic end_job(input int id, input int delay, input bit never,
                           input logic match, input logic [4:0] idx);
        eng_t e;
        res_t r;
        e.delay = delay; e.never = never; e.match = match; e.idx = idx;
        eng_q.push_back(e);
        r.id     = (id == 1);
        r.match  = never ? 1'b0 : match;
        r.idx    = never ? 5'd0 : idx;
        r.tmo    = never;
        r.lenerr = job_lenerr;
        exp_res.push_back(r);
        job_lenerr = 0;
    endtask

    // One clock: observe registered outputs, drive inputs, then account for accepts
    task automatic cycle();
        beat_t b;
        fwd_t  f;
        res_t  r;
        eng_t  e;
        logic [1:0] own_mask;
        @(negedge clk);
        if (sme_isstring || sme_ispattern) begin
            if (exp_fwd.size() == 0) begin
                chk("fwd_extra", {30'd0, sme_isstring, sme_ispattern}, 32'd0);
            end else begin
                f = exp_fwd.pop_front();
                chk("fwd_strobe", {30'd0, sme_isstring, sme_ispattern}, f.typ ? 32'd1 : 32'd2);
                chk("fwd_char", 32'(sme_chardata), 32'(f.ch));
            end
        end
        if (len_err) lenerr_cnt++;
        if (lat_on) begin
            lat_cnt++;
            if (res_valid || lat_cnt > lat_exp + 4) begin
                chk("res_latency", lat_cnt, lat_exp);
                lat_on  = 0;
                waiting = 0;
            end
        end
        sme_valid       = 1'b0;
        sme_match       = 1'($urandom);
        sme_match_index = 5'($urandom);
        if (waiting) begin
            if (!e_never) begin
                if (timer == 0) begin
                    sme_valid       = 1'b1;
                    sme_match       = e_match;
                    sme_match_index = e_idx;
                    waiting         = 0;
                end else begin
                    timer--;
                end
            end
        end else begin
            sme_valid = ($urandom_range(0, 7) == 0);
        end
        res_ready = ($urandom_range(0, 2) != 0);
        for (int i = 0; i < 2; i++) begin
            if (hd[i] < tl[i]) begin
                b = mem[i][hd[i]];
                req_valid[i] = b.first ? 1'b1 : ($urandom_range(0, 3) != 0);
                req_type[i]  = b.typ;
                req_last[i]  = b.last;
                req_char[8*i +: 8] = b.ch;
            end else begin
                req_valid[i] = 1'b0;
                req_type[i]  = 1'($urandom);
                req_last[i]  = 1'($urandom);
                req_char[8*i +: 8] = 8'($urandom);
            end
        end
        #1;
        if (exp_res.size() > 0) begin
            own_mask = exp_res[0].id ? 2'b10 : 2'b01;
            if ((req_ready & ~own_mask) != 2'b00) bad_ready = 1;
        end
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                b = mem[i][hd[i]];
                hd[i]++;
                if (b.typ && b.last) begin
                    if (eng_q.size() == 0) begin
                        chk("eng_underflow", 32'd1, 32'd0);
                    end else begin
                        e       = eng_q.pop_front();
                        waiting = 1;
                        e_never = e.never;
                        e_match = e.match;
                        e_idx   = e.idx;
                        timer   = e.delay;
                        lat_on  = 1;
                        lat_cnt = 0;
                        lat_exp = e.never ? WDOG + 1 : e.delay + 2;
                    end
                end
            end
        end
        if (res_valid && res_ready) begin
            if (exp_res.size() == 0) begin
                chk("res_extra", 32'd1, 32'd0);
            end else begin
                r = exp_res.pop_front();
                chk("res_id", 32'(res_id), 32'(r.id));
                chk("res_match", 32'(res_match), 32'(r.match));
                chk("res_index", 32'(res_index), 32'(r.idx));
                chk("res_timeout", 32'(res_timeout), 32'(r.tmo));
                chk("len_err_cnt", lenerr_cnt, r.lenerr);
                chk("ready_excl", 32'(bad_ready), 32'd0);
            end
            lenerr_cnt = 0;
            bad_ready  = 0;
        end
    endtask

    task automatic run_all(input int budget);
        int n;
        n = 0;
        while (exp_res.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("jobs_done", exp_res.size(), 32'd0);
        chk("fwd_left", exp_fwd.size(), 32'd0);
    endtask

    initial begin
        int n;
        reset           = 1'b0;
        req_valid       = 2'b11;
        req_type        = 2'b01;
        req_char        = 16'h6162;
        req_last        = 2'b00;
        res_ready       = 1'b1;
        sme_valid       = 1'b1;
        sme_match       = 1'b1;
        sme_match_index = 5'h1f;
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'(outs), 32'd0);
        reset     = 1'b1;
        req_valid = 2'b00;
        sme_valid = 1'b0;

        // Directed jobs first, in expected grant order (requesters alternate)
        add_str(0, 1'b0, "abcd", 1); add_str(0, 1'b1, "bc", 0); end_job(0, 3, 0, 1'b1, 5'd1);
        add_str(1, 1'b0, "xyz", 1);  add_str(1, 1'b1, "yz", 0); end_job(1, 6, 0, 1'b0, 5'd9);
        add_str(0, 1'b1, "abcdefghij", 1);                      end_job(0, 0, 0, 1'b1, 5'd31);
        add_str(1, 1'b1, "kl", 1);                              end_job(1, 0, 1, 1'b0, 5'd0);
        for (int j = 0; j < 12; j++) begin
            int id;
            int ns;
            id = j % 2;
            ns = $urandom_range(0, 2);
            for (int p = 0; p < ns; p++) add_rnd(id, 1'b0, $urandom_range(1, 40), p == 0);
            add_rnd(id, 1'b1, $urandom_range(1, 12), ns == 0);
            end_job(id, $urandom_range(0, 12), 0, 1'($urandom), 5'($urandom));
        end
        run_all(60000);

        // Reset while the engine is being waited on, then a clean job afterwards
        add_str(0, 1'b1, "q", 1); end_job(0, 0, 1, 1'b0, 5'd0);
        n = 0;
        while (!(waiting && lat_cnt >= 20) && n < 300) begin
            cycle();
            n++;
        end
        chk("reached_wait", 32'(waiting), 32'd1);
        #2 reset = 1'b0;
        #1 chk("reset_async", 32'(outs), 32'd0);
        exp_res.delete();
        exp_fwd.delete();
        eng_q.delete();
        waiting    = 0;
        lat_on     = 0;
        lenerr_cnt = 0;
        bad_ready  = 0;
        job_lenerr = 0;
        hd[0] = tl[0];
        hd[1] = tl[1];
        req_valid = 2'b11;
        repeat (3) @(negedge clk);
        chk("reset_hold", 32'(outs), 32'd0);
        reset     = 1'b1;
        req_valid = 2'b00;
        sme_valid = 1'b0;
        add_str(0, 1'b0, "hi", 1); add_str(0, 1'b1, "ih", 0); end_job(0, 2, 0, 1'b1, 5'd5);
        add_str(1, 1'b1, "ab", 1);                            end_job(1, 5, 0, 1'b1, 5'd17);
        run_all(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
